// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic single-cycle bus master. It takes read/write commands on a
// valid/ready port and runs exactly one Wishbone transaction at a time. It
// returns the read data, or a timeout error, on a valid/ready response port.
// This is the initiator used for on-chip self-test and sequencing of our
// peripherals without involving the management core.
//
// Build option:
//   WB_TIMEOUT_EN  when defined, a 16-bit timeout counter aborts a transaction
//                  that is not acked within TIMEOUT_CYCLES cycles and reports
//                  rsp_err=1. When undefined, the master waits for ack
//                  forever, rsp_err is tied low and TIMEOUT_CYCLES is unused.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum cycles cyc/stb stay high without ack (1..65535)
//
// Ports:
//   wb_clk_i, wb_rst_ni         clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_ready is high in IDLE
//   cmd_we, cmd_adr, cmd_dat,   command fields: 1 = write, byte address,
//   cmd_sel                     write data, byte selects
//   rsp_valid/rsp_ready         response handshake
//   rsp_dat, rsp_err            read data (0 for writes and errors), timeout
//   wbm_*                       Wishbone master signals
//   busy                        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  // Wishbone master
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  // status
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg;
  logic        busy_reg;
  logic        cyc_reg;
  logic        stb_reg;
  logic        we_reg;
  logic [3:0]  sel_reg;
  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_dat_reg;

  // An out-of-range TIMEOUT_CYCLES would make the 16-bit compare meaningless.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef WB_TIMEOUT_EN
  // The last BUS edge is the one at which the count equals TIMEOUT_CYCLES-1;
  // together with the entry edge that keeps cyc high for exactly
  // TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_reg;
  logic        rsp_err_reg;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt_reg == TMO_LAST);
  assign rsp_err = rsp_err_reg;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= 4'h0;
      adr_reg       <= 32'h0;
      dat_reg       <= 32'h0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= 32'h0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt_reg   <= 16'h0;
      rsp_err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            // Wishbone address/data/select/we are loaded once and held for
            // the whole cycle; they also keep their values after cyc drops.
            we_reg    <= cmd_we;
            adr_reg   <= cmd_adr;
            dat_reg   <= cmd_dat;
            sel_reg   <= cmd_sel;
            cyc_reg   <= 1'b1;
            stb_reg   <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= BUS;
`ifdef WB_TIMEOUT_EN
            tmo_cnt_reg <= 16'h0;
`endif
          end
        end

        BUS: begin
          // Ack is tested first so an ack on the timeout edge still succeeds.
          if (wbm_ack_i) begin
            rsp_dat_reg   <= we_reg ? 32'h0 : wbm_dat_i;
            rsp_valid_reg <= 1'b1;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            state_reg     <= RESP;
`ifdef WB_TIMEOUT_EN
            rsp_err_reg   <= 1'b0;
          end else if (tmo_hit) begin
            rsp_dat_reg   <= 32'h0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            state_reg     <= RESP;
          end else begin
            tmo_cnt_reg   <= tmo_cnt_reg + 16'd1;
`endif
          end
        end

        RESP: begin
          // Returning to IDLE here (rather than straight to BUS) means a new
          // command is never taken on the response handshake edge.
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          cyc_reg   <= 1'b0;
          stb_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = busy_reg;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = stb_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_sel_o = sel_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_dat   = rsp_dat_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_master
//
// Self-checking bench for wb_cmd_master with TIMEOUT_CYCLES=8. Directed
// scenarios follow the block's test plan; a randomized loop compares each
// transaction against an outcome model derived from the block's rules
// (bus cycles, error flag and response data as a function of ack position).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wb_cmd_master;

  localparam int T = 8;
`ifdef WB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i (wb_clk_i),  .wb_rst_ni(wb_rst_ni),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),   .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),   .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),  .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy     (busy)
  );

  // Outcome model: ack_at is the bus cycle (1-based) in which the slave acks,
  // 0 meaning it never acks.
  function automatic void model(input bit we, input logic [31:0] rdata,
                                input int ack_at, output int exp_cycles,
                                output bit exp_err, output logic [31:0] exp_dat);
    if (TMO_EN && (ack_at == 0 || ack_at > T)) begin
      exp_cycles = T;
      exp_err    = 1'b1;
      exp_dat    = 32'h0;
    end else begin
      exp_cycles = ack_at;
      exp_err    = 1'b0;
      exp_dat    = we ? 32'h0 : rdata;
    end
  endfunction

  // Drives one command, plays the slave, optionally back-pressures the
  // response for 'hold' cycles (with a pending command and stray acks), then
  // completes the handshake. Only observations are returned.
  task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at,
                        input logic [31:0] rdata, input int hold,
                        output int cyc_cnt, output bit ctrl_ok, output bit got_rsp,
                        output logic [31:0] r_dat, output bit r_err,
                        output bit hold_ok, output bit ready_after);
    @(negedge wb_clk_i);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    ctrl_ok = (cmd_ready === 1'b1) && (wbm_cyc_o === 1'b0);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    cmd_adr = $urandom; cmd_dat = $urandom; cmd_we = ~we;
    cyc_cnt = 0;
    for (int i = 0; i < 300 && wbm_cyc_o === 1'b1; i++) begin
      cyc_cnt++;
      if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
          wbm_dat_o !== dat || wbm_sel_o !== sel || busy !== 1'b1 ||
          cmd_ready !== 1'b0)
        ctrl_ok = 1'b0;
      wbm_ack_i = (cyc_cnt == ack_at);
      wbm_dat_i = (cyc_cnt == ack_at) ? rdata : $urandom;
      @(negedge wb_clk_i);
    end
    wbm_ack_i = 1'b0;
    got_rsp = (rsp_valid === 1'b1) && (wbm_cyc_o === 1'b0) && (wbm_stb_o === 1'b0);
    r_dat = rsp_dat;
    r_err = rsp_err;
    hold_ok = 1'b1;
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_we = $urandom; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = $urandom;
    end
    for (int i = 0; i < hold; i++) begin
      wbm_ack_i = $urandom_range(0, 1);
      wbm_dat_i = $urandom;
      @(negedge wb_clk_i);
      if (rsp_valid !== 1'b1 || rsp_dat !== r_dat || rsp_err !== r_err ||
          cmd_ready !== 1'b0 || busy !== 1'b1 || wbm_cyc_o !== 1'b0)
        hold_ok = 1'b0;
    end
    wbm_ack_i = 1'b0;
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    ready_after = (cmd_ready === 1'b1) && (rsp_valid === 1'b0) &&
                  (busy === 1'b0) && (wbm_cyc_o === 1'b0);
    cmd_valid = 1'b0;
    $display("txn we=%0d adr=%h ack_at=%0d hold=%0d -> cycles=%0d rsp=%0d dat=%h err=%0d",
             we, adr, ack_at, hold, cyc_cnt, got_rsp, r_dat, r_err);
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b busy=%b rsp_valid=%b rsp_err=%b, want 1 0 0 0",
               cmd_ready, busy, rsp_valid, rsp_err);
    end
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 ||
        wbm_sel_o !== 4'h0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 ||
        rsp_dat !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rsp_dat=%h, want all 0",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_dat);
    end
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
  endtask

  task automatic test_write();
    int c; bit ok, gr, e, ho, ra; logic [31:0] d;
    do_txn(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 3, 32'hDEAD_BEEF, 0,
           c, ok, gr, d, e, ho, ra);
    checks++;
    if (c != 3) begin failures++; $display("FAIL write_cycles: got %0d want 3", c); end
    checks++;
    if (!ok) begin failures++; $display("FAIL write_ctrl_stable: got 0 want 1"); end
    checks++;
    if (!gr || d !== 32'h0 || e !== 1'b0) begin
      failures++;
      $display("FAIL write_rsp: valid=%0d dat=%h err=%0d want 1 00000000 0", gr, d, e);
    end
    checks++;
    if (!ra) begin failures++; $display("FAIL write_idle_after: got 0 want 1"); end
  endtask

  task automatic test_read();
    int c; bit ok, gr, e, ho, ra; logic [31:0] d;
    do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 0,
           c, ok, gr, d, e, ho, ra);
    // one bus cycle means rsp_valid two cycles after the command edge
    checks++;
    if (c != 1 || !gr) begin
      failures++;
      $display("FAIL read_latency: cycles=%0d rsp=%0d want 1 1", c, gr);
    end
    checks++;
    if (d !== 32'hCAFE_F00D || e !== 1'b0 || !ok) begin
      failures++;
      $display("FAIL read_rsp: dat=%h err=%0d ctrl=%0d want cafef00d 0 1", d, e, ok);
    end
  endtask

  task automatic test_timeout();
    int c; bit ok, gr, e, ho, ra; logic [31:0] d;
    int ack_at;
    ack_at = TMO_EN ? 0 : 20;   // without the timeout build, ack late instead
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'h3, ack_at, 32'h5555_AAAA, 0,
           c, ok, gr, d, e, ho, ra);
    checks++;
    if (c != (TMO_EN ? T : 20)) begin
      failures++;
      $display("FAIL timeout_cycles: got %0d want %0d", c, TMO_EN ? T : 20);
    end
    checks++;
    if (!gr || e !== TMO_EN || d !== (TMO_EN ? 32'h0 : 32'h5555_AAAA)) begin
      failures++;
      $display("FAIL timeout_rsp: valid=%0d err=%0d dat=%h want 1 %0d %h",
               gr, e, d, TMO_EN, TMO_EN ? 32'h0 : 32'h5555_AAAA);
    end
  endtask

  task automatic test_ack_at_limit();
    int c; bit ok, gr, e, ho, ra; logic [31:0] d;
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, T, 32'h0BAD_F00D, 0,
           c, ok, gr, d, e, ho, ra);
    checks++;
    if (c != T || !gr || e !== 1'b0 || d !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL ack_at_limit: cycles=%0d rsp=%0d err=%0d dat=%h want %0d 1 0 0badf00d",
               c, gr, e, d, T);
    end
  endtask

  task automatic test_stray_ack_idle();
    bit bad = 1'b0;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wbm_ack_i = 1'b1;
      wbm_dat_i = $urandom;
      @(negedge wb_clk_i);
      if (wbm_cyc_o !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
        bad = 1'b1;
    end
    wbm_ack_i = 1'b0;
    checks++;
    if (bad) begin failures++; $display("FAIL stray_ack_idle: state changed, want none"); end
  endtask

  task automatic test_backpressure();
    int c; bit ok, gr, e, ho, ra; logic [31:0] d;
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hC, 2, 32'h1357_9BDF, 5,
           c, ok, gr, d, e, ho, ra);
    checks++;
    if (!ho) begin failures++; $display("FAIL bp_hold: rsp/ready/busy not held, got 0 want 1"); end
    checks++;
    if (!gr || d !== 32'h1357_9BDF || c != 2) begin
      failures++;
      $display("FAIL bp_rsp: rsp=%0d dat=%h cycles=%0d want 1 13579bdf 2", gr, d, c);
    end
    // the command held during the handshake must not have started a cycle
    checks++;
    if (!ra) begin failures++; $display("FAIL bp_no_same_cycle_accept: got 0 want 1"); end
    do_txn(1'b1, 32'h3000_000C, 32'hA5A5_5A5A, 4'h1, 1, 32'h0, 0,
           c, ok, gr, d, e, ho, ra);
    checks++;
    if (!ok || c != 1 || !gr || d !== 32'h0) begin
      failures++;
      $display("FAIL bp_next_cmd: ctrl=%0d cycles=%0d rsp=%0d dat=%h want 1 1 1 0", ok, c, gr, d);
    end
  endtask

  task automatic test_reset_mid();
    int c; bit ok, gr, e, ho, ra; logic [31:0] d;
    bit bad = 1'b0;
    @(negedge wb_clk_i);
    cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'hFFFF_0000; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL rst_mid_in_bus: cyc=%b want 1", wbm_cyc_o); end
    #2 wb_rst_ni = 1'b0;
    #1;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0 ||
        wbm_we_o !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: cyc=%b stb=%b busy=%b ready=%b adr=%h want 0 0 0 1 0",
               wbm_cyc_o, wbm_stb_o, busy, cmd_ready, wbm_adr_o);
    end
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wbm_ack_i = 1'b1;
      rsp_ready = 1'b0;
      @(negedge wb_clk_i);
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    wbm_ack_i = 1'b0;
    checks++;
    if (bad) begin failures++; $display("FAIL rst_mid_no_rsp: activity after reset, want none"); end
    do_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 2, 32'h2468_ACE0, 0,
           c, ok, gr, d, e, ho, ra);
    checks++;
    if (!ok || c != 2 || !gr || d !== 32'h2468_ACE0 || e !== 1'b0 || !ra) begin
      failures++;
      $display("FAIL rst_mid_next_cmd: ctrl=%0d cycles=%0d rsp=%0d dat=%h err=%0d want 1 2 1 2468ace0 0",
               ok, c, gr, d, e);
    end
  endtask

  task automatic test_random();
    int c; bit ok, gr, e, ho, ra; logic [31:0] d;
    int exp_c; bit exp_e; logic [31:0] exp_d;
    bit we; logic [31:0] adr, dat, rdata; logic [3:0] sel; int ack_at, hold;
    for (int n = 0; n < 40; n++) begin
      we = $urandom_range(0, 1);
      adr = $urandom; dat = $urandom; sel = $urandom; rdata = $urandom;
      ack_at = TMO_EN ? $urandom_range(0, T + 3) : $urandom_range(1, T + 3);
      hold = $urandom_range(0, 3);
      model(we, rdata, ack_at, exp_c, exp_e, exp_d);
      do_txn(we, adr, dat, sel, ack_at, rdata, hold, c, ok, gr, d, e, ho, ra);
      checks++;
      if (c != exp_c || !gr || d !== exp_d || e !== exp_e || !ok || !ho || !ra) begin
        failures++;
        $display("FAIL random_%0d: cycles=%0d dat=%h err=%0d rsp=%0d ctrl=%0d hold=%0d idle=%0d want cycles=%0d dat=%h err=%0d all flags 1",
                 n, c, d, e, gr, ok, ho, ra, exp_c, exp_d, exp_e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_limit();
    test_stray_ack_idle();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-cycle bus master for the user project area. It accepts simple read/write commands on a valid/ready port and drives one Wishbone transaction at a time toward a slave peripheral, such as the QARMA cipher register block. It returns the read data or a timeout error on a valid/ready response port. It is the initiator end of the bus our peripherals answer on, used for on-chip self-test and sequencing without the management core.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum cycles cyc/stb stay asserted without ack (range 1..65535).

Ports:
- wb_clk_i  in  1  sole clock, all logic rising-edge
- wb_rst_ni  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready at rising edge
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_dat  out  32  read data (0 for writes and errors)
- rsp_err  out  1  1 = transaction timed out
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone controls
- wbm_sel_o  out  4; wbm_adr_o  out  32; wbm_dat_o  out  32
- wbm_ack_i  in  1; wbm_dat_i  in  32
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, BUS, RESP. All outputs are registered.
- Reset values:
  - State is IDLE. cmd_ready=1 (combinational from state).
  - rsp_valid, rsp_err, cyc, stb, we, and busy are 0.
  - rsp_dat, sel, adr, and wbm_dat_o are 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, clear the timeout counter, and go to BUS.
- BUS:
  - cyc, stb, we, sel, adr, and dat are held stable.
  - On a sampled wbm_ack_i:
    - Capture rsp_dat = wbm_dat_i for reads, or 0 for writes.
    - Set rsp_err=0 and rsp_valid=1.
    - Drop cyc and stb, then go to RESP.
  - On timeout without ack: rsp_dat=0, rsp_err=1, rsp_valid=1, drop cyc and stb, go to RESP.
  - Ack and timeout at the same edge: ack wins (success).
- RESP:
  - rsp_* are held stable while rsp_ready=0.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - A new command is not accepted in the same cycle as the response handshake.
- wbm_ack_i sampled outside BUS is ignored and causes no state change.
- we/sel/adr/dat keep their last values after cyc drops. cyc=0 qualifies them.
- Reset assertion in any state immediately (asynchronously) forces all reset values. An in-flight transaction is abandoned and no response is produced.

## Timing
- Command accepted at edge E0: cyc/stb are high from E0 through the edge that samples ack.
- Ack sampled at edge E1: cyc/stb are low and rsp_valid is high after E1. The minimum is E1 = E0+1, giving 2 cycles from command to response.
- Throughput is at most one transaction per 3 cycles (IDLE, BUS, RESP).
- Timeout counter:
  - Increments at each BUS edge without ack.
  - Abort occurs at the edge where the count equals TIMEOUT_CYCLES-1, so cyc stays high for exactly TIMEOUT_CYCLES cycles.
- Counter width is 16 bits. It never wraps because it is cleared on every BUS entry.

## Configuration
- WB_TIMEOUT_EN defined: the timeout counter and abort path are built as described.
- WB_TIMEOUT_EN undefined:
  - No counter logic is built. BUS waits for ack indefinitely.
  - rsp_err is tied 0. TIMEOUT_CYCLES is ignored.

## Test plan
- Write: cmd we=1, adr=0x3000_0004, dat=0x1234_5678, sel=0xF; slave acks in its 3rd cycle.
  - Expect cyc/stb/we high exactly 3 cycles with adr/dat/sel stable.
  - Then rsp_valid=1, rsp_err=0, rsp_dat=0.
- Read: cmd we=0, adr=0x3000_0000; slave acks in the first cycle with 0xCAFE_F00D.
  - Expect rsp_valid 2 cycles after the command edge, rsp_dat=0xCAFE_F00D, rsp_err=0.
- Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=8): no ack.
  - Expect cyc high exactly 8 cycles, then rsp_err=1, rsp_dat=0.
- Ack on the 8th BUS cycle with TIMEOUT_CYCLES=8: success with rsp_err=0.
- Stray ack during IDLE and RESP: no state change.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1.
  - Expect rsp_* stable, cmd_ready=0, busy=1, and no second cycle.
  - After the handshake, the next command is accepted 1 cycle later.
- Reset mid-transaction: drive wb_rst_ni low in BUS between clock edges.
  - Expect cyc/stb=0 immediately, all outputs at reset values, and no response after release.
  - The next command then completes normally.
